det_window_cnt: RTL and testbench

Downstream consumer of the `seq_101det` stage. It counts `flag_101` hit pulses over fixed-length windows of qualified input bits. At the end of each window it presents the hit count on a valid/ready output port. It sits between the serial pattern detector and the statistics/reporting logic, and turns a per-bit pulse stream into one per-window count word.

---
 rtl/seq_det_pkg.sv | 26 ++
 rtl/det_window_cnt_if.sv | 16 +
 rtl/det_window_cnt_sat_cnt.sv | 43 ++++
 rtl/det_window_cnt.sv | 120 ++++++++++++
 tb/tb_det_window_cnt.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the seq_101det stage and its downstream consumers:
// FSM state encoding, default parameters and a constant clog2 helper.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DET_WIN_LEN_DEF = 16;
    localparam int DET_CNT_W_DEF   = 8;

    // Usable in parameter context; returns at least 1 for values of 2 or more.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/det_window_cnt_if.sv
// Result channel of det_window_cnt: valid/ready handshake carrying the window
// hit count, its saturation flag and the sticky overrun flag.
interface det_window_cnt_if
    import seq_det_pkg::*;
#(
    parameter int CNT_W = DET_CNT_W_DEF
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic             out_sat;
    logic             overrun;

    modport master (output out_valid, out_cnt, out_sat, overrun, input out_ready);
    modport slave  (input out_valid, out_cnt, out_sat, overrun, output out_ready);
endinterface

// File: rtl/det_window_cnt_sat_cnt.sv
// sat_cnt: saturating incrementer with synchronous clear; exposes the value and
// sat flag as they stand after this cycle's increment so a caller can capture both.
module sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             sat_nxt
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic             sat;

    // NOTE: every output of the block gets a default first, so no latch is inferred.
    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (inc) begin
            // An increment lost at the ceiling is what marks the count as saturated.
            if (cnt == MAX) sat_nxt = 1'b1;
            else            cnt_nxt = cnt + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= sat_nxt;
        end
    end

endmodule

// File: rtl/det_window_cnt.sv
// det_window_cnt: counts flag_101 hits per window of WIN_LEN qualified bits and offers
// each count on a valid/ready port. Define DET_WIN_OVERRUN_EN to keep pending results and flag overrun.
module det_window_cnt
    import seq_det_pkg::*;
#(
    parameter int WIN_LEN = DET_WIN_LEN_DEF,
    parameter int CNT_W   = DET_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_en,
    input  logic             flag_101,
    det_window_cnt_if.master res
);
    localparam int               BIT_W    = clog2(WIN_LEN);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIN_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic             running;
    logic             counting;
    logic             win_done;
    logic             hit_clr;
    logic             hit_inc;
    logic [CNT_W-1:0] hit_nxt;
    logic             hit_sat_nxt;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             xfer;

    // An edge with en low already leaves RUN, so it never counts a bit.
    assign running  = (state == ST_RUN) && en;
    assign counting = running && bit_en;
    assign win_done = counting && (bit_cnt == LAST_BIT);
    assign hit_clr  = !running || win_done;
    assign hit_inc  = counting && flag_101;
    assign xfer     = valid_q && res.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en)  state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = ST_IDLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    bit_cnt <= '0;
        else if (!running || win_done) bit_cnt <= '0;
        else if (bit_en)               bit_cnt <= bit_cnt + BIT_W'(1);
    end

    sat_cnt #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (hit_clr),
        .inc     (hit_inc),
        .cnt_nxt (hit_nxt),
        .sat_nxt (hit_sat_nxt)
    );

`ifdef DET_WIN_OVERRUN_EN
    logic load_ok;
    logic ovr_q;

    assign load_ok = !valid_q || res.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (win_done && load_ok) begin
                valid_q <= 1'b1;
                cnt_q   <= hit_nxt;
                sat_q   <= hit_sat_nxt;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            // Set is tested first so it wins over a same-edge clear.
            if (win_done && !load_ok) ovr_q <= 1'b1;
            else if (xfer)            ovr_q <= 1'b0;
        end
    end

    assign res.overrun = ovr_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else if (win_done) begin
            valid_q <= 1'b1;
            cnt_q   <= hit_nxt;
            sat_q   <= hit_sat_nxt;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    assign res.overrun = 1'b0;
`endif

    assign res.out_valid = valid_q;
    assign res.out_cnt   = cnt_q;
    assign res.out_sat   = sat_q;

endmodule

// File: tb/tb_det_window_cnt.sv
// Self-checking bench for det_window_cnt: scoreboard of expected window results
// popped on each handshake transfer, plus direct checks of timing, reset and overrun.
module tb_det_window_cnt;
    import seq_det_pkg::*;

    localparam int WIN_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int SAT_W   = 2;

    typedef struct {
        int cnt;
        bit sat;
    } res_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b0;
    logic en_s     = 1'b0;
    logic bit_en   = 1'b0;
    logic flag_101 = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];
    res_t sat_q[$];

    det_window_cnt_if #(.CNT_W(CNT_W)) res_if ();
    det_window_cnt_if #(.CNT_W(SAT_W)) sat_if ();

    det_window_cnt #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bit_en   (bit_en),
        .flag_101 (flag_101),
        .res      (res_if)
    );

    det_window_cnt #(.WIN_LEN(WIN_LEN), .CNT_W(SAT_W)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_s),
        .bit_en   (bit_en),
        .flag_101 (flag_101),
        .res      (sat_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [WIN_LEN-1:0] flags, input int w);
        res_t r;
        r.cnt = 0;
        r.sat = 1'b0;
        for (int i = 0; i < WIN_LEN; i++) begin
            if (flags[i]) begin
                if (r.cnt == (1 << w) - 1) r.sat = 1'b1;
                else                       r.cnt++;
            end
        end
        return r;
    endfunction

    // Scoreboards: each transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (res_if.out_valid && res_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("main_unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("main_cnt", 32'(res_if.out_cnt), 32'(e.cnt));
                check("main_sat", 32'(res_if.out_sat), 32'(e.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (sat_if.out_valid && sat_if.out_ready) begin
            if (sat_q.size() == 0) begin
                check("sat_unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sat_q.pop_front();
                check("satdut_cnt", 32'(sat_if.out_cnt), 32'(e.cnt));
                check("satdut_sat", 32'(sat_if.out_sat), 32'(e.sat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic be, input logic fl);
        bit_en   = be;
        flag_101 = fl;
        step();
    endtask

    task automatic start();
        en       = 1'b1;
        bit_en   = 1'b0;
        flag_101 = 1'b0;
        step();
    endtask

    task automatic stop();
        en       = 1'b0;
        bit_en   = 1'b0;
        flag_101 = 1'b0;
        step();
        step();
    endtask

    task automatic push_main(input logic [WIN_LEN-1:0] flags);
        exp_q.push_back(model(flags, CNT_W));
    endtask

    task automatic run_window(input logic [WIN_LEN-1:0] flags, input bit chk);
        for (int i = 0; i < WIN_LEN; i++) begin
            drive_bit(1'b1, flags[i]);
            if (chk && i == 0)           check("one_cycle_valid", 32'(res_if.out_valid), 32'd0);
            if (chk && i == WIN_LEN - 2) check("early_valid", 32'(res_if.out_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res_t bp;
        logic exp_ovr;

        res_if.out_ready = 1'b1;
        sat_if.out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(res_if.out_valid), 32'd0);
        check("reset_cnt",   32'(res_if.out_cnt),   32'd0);
        check("reset_sat",   32'(res_if.out_sat),   32'd0);
        check("reset_ovr",   32'(res_if.overrun),   32'd0);
        rst_n = 1'b1;
        step();

        // Basic count: hits on bits 3, 5, 7, then a hit on bit 8 only
        start();
        push_main(8'b0101_0100);
        run_window(8'b0101_0100, 1'b1);
        check("basic_valid", 32'(res_if.out_valid), 32'd1);
        check("basic_cnt",   32'(res_if.out_cnt),   32'd3);
        push_main(8'b1000_0000);
        run_window(8'b1000_0000, 1'b1);
        check("last_bit_valid", 32'(res_if.out_valid), 32'd1);
        check("last_bit_cnt",   32'(res_if.out_cnt),   32'd1);
        stop();

        // Backpressure across two windows with counts 2 and 4
        res_if.out_ready = 1'b0;
        start();
`ifdef DET_WIN_OVERRUN_EN
        bp      = model(8'b0000_0011, CNT_W);
        exp_ovr = 1'b1;
`else
        bp      = model(8'b0000_1111, CNT_W);
        exp_ovr = 1'b0;
`endif
        exp_q.push_back(bp);
        run_window(8'b0000_0011, 1'b0);
        run_window(8'b0000_1111, 1'b0);
        check("bp_valid", 32'(res_if.out_valid), 32'd1);
        check("bp_cnt",   32'(res_if.out_cnt),   32'(bp.cnt));
        check("bp_ovr",   32'(res_if.overrun),   32'(exp_ovr));
        stop();
        check("bp_hold_valid", 32'(res_if.out_valid), 32'd1);
        check("bp_hold_cnt",   32'(res_if.out_cnt),   32'(bp.cnt));
        res_if.out_ready = 1'b1;
        step();
        check("bp_valid_clr", 32'(res_if.out_valid), 32'd0);
        check("bp_ovr_clr",   32'(res_if.overrun),   32'd0);

        // Reset at bit 5 of a window while a result is pending
        res_if.out_ready = 1'b0;
        start();
        run_window(8'b0000_0001, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1);
        bit_en   = 1'b1;
        flag_101 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(res_if.out_valid), 32'd0);
        check("rst_async_cnt",   32'(res_if.out_cnt),   32'd0);
        check("rst_async_sat",   32'(res_if.out_sat),   32'd0);
        check("rst_async_ovr",   32'(res_if.overrun),   32'd0);
        en       = 1'b0;
        bit_en   = 1'b0;
        flag_101 = 1'b0;
        step();
        rst_n            = 1'b1;
        res_if.out_ready = 1'b1;
        step();
        start();
        push_main(8'b0011_0000);
        run_window(8'b0011_0000, 1'b1);
        check("rst_after_valid", 32'(res_if.out_valid), 32'd1);
        check("rst_after_cnt",   32'(res_if.out_cnt),   32'd2);
        stop();

        // Saturation on a CNT_W=2 instance
        en_s = 1'b1;
        step();
        sat_q.push_back(model(8'hFF, SAT_W));
        run_window(8'hFF, 1'b0);
        check("sat_cnt",  32'(sat_if.out_cnt), 32'd3);
        check("sat_flag", 32'(sat_if.out_sat), 32'd1);
        sat_q.push_back(model(8'h00, SAT_W));
        run_window(8'h00, 1'b0);
        check("sat_clr_cnt",  32'(sat_if.out_cnt), 32'd0);
        check("sat_clr_flag", 32'(sat_if.out_sat), 32'd0);
        en_s = 1'b0;
        stop();

        // Abort after bit 5, re-enable three cycles later
        start();
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1);
        en = 1'b0;
        drive_bit(1'b1, 1'b1);
        check("abort_valid", 32'(res_if.out_valid), 32'd0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        check("abort_idle_valid", 32'(res_if.out_valid), 32'd0);
        start();
        push_main(8'b0000_0010);
        run_window(8'b0000_0010, 1'b1);
        check("abort_next_valid", 32'(res_if.out_valid), 32'd1);
        check("abort_next_cnt",   32'(res_if.out_cnt),   32'd1);
        stop();

        // Gaps: flags only on unqualified cycles
        start();
        push_main(8'h00);
        for (int i = 0; i < WIN_LEN; i++) begin
            drive_bit(1'b0, 1'b1);
            if (i == WIN_LEN - 1) check("gap_early_valid", 32'(res_if.out_valid), 32'd0);
            drive_bit(1'b1, 1'b0);
        end
        check("gap_valid", 32'(res_if.out_valid), 32'd1);
        check("gap_cnt",   32'(res_if.out_cnt),   32'd0);
        stop();

        check("main_queue_empty", 32'(exp_q.size()), 32'd0);
        check("sat_queue_empty",  32'(sat_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
